// File: rtl/gt_usplus_qpll_pkg.sv
// Shared types and helpers for the GTYE4 QPLL0 reset sequencer.
package gt_usplus_qpll_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    LOCKED    = 3'd3,
    FAIL      = 3'd4
  } qpll_seq_state_t;

  // Quads that are actually populated; unused lock bits are forced high.
  function automatic logic [1:0] active_mask(input int n_common);
    return (n_common == 2) ? 2'b11 : 2'b01;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gt_usplus_sync_2ff.sv
// Single-bit two-flop synchronizer for the asynchronous QPLL lock status.
module gt_usplus_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gt_usplus_qpll_reset_sequencer.sv
// QPLL0 reset/lock sequencer: pulses QPLL0 reset, qualifies lock, then releases
// the downstream GT channel reset. Retries on timeout, latches FAIL after MAX_RETRIES.
module gt_usplus_qpll_reset_sequencer
  import gt_usplus_qpll_pkg::*;
#(
  parameter int N_COMMON            = 2,
  parameter int RESET_PULSE_CYCLES  = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 200000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 7,
  localparam int RW                 = $clog2(MAX_RETRIES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart,
  input  logic [1:0]    qpll0lock,
  output logic [1:0]    qpll0reset,
  output logic [1:0]    qpll1reset,
  output logic          gt_reset_req,
  output logic          qpll_locked,
  output logic          timeout_err,
  output logic [RW-1:0] retry_cnt,
  output logic [2:0]    seq_state
);

  localparam logic [1:0] MASK  = active_mask(N_COMMON);
  localparam int         CMAX  = max3(RESET_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int         CNT_W = $clog2(CMAX + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  // The WAIT_LOCK sample that enters STABLE is the first cycle of the stable window.
  localparam logic [CNT_W-1:0] STB_LAST   =
    CNT_W'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
  localparam logic [RW-1:0]    RMAX       = RW'(MAX_RETRIES);

  logic [1:0] lock_s;
  logic       lock_all;

  for (genvar i = 0; i < 2; i++) begin : g_sync
    gt_usplus_sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (qpll0lock[i]),
      .q_o   (lock_s[i])
    );
  end

  assign lock_all = &(lock_s | ~MASK);

  qpll_seq_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [1:0]       qpll0reset_q, qpll1reset_q;
  logic             gt_reset_req_q, qpll_locked_q, timeout_err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (restart) begin
      state_d = RESET_PLL;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == PULSE_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          cnt_d = cnt_q + 1'b1;
          if (lock_all) begin
            state_d = STABLE;
          end else if (cnt_q == TO_LAST) begin
            if (retry_q == RMAX) begin
              state_d = FAIL;
            end else begin
              state_d = RESET_PLL;
              retry_d = retry_q + RW'(1);
            end
          end
        end
        STABLE: begin
          cnt_d = cnt_q + 1'b1;
          if (!lock_all)              state_d = WAIT_LOCK;
          else if (cnt_q == STB_LAST) state_d = LOCKED;
        end
        LOCKED: if (!lock_all) state_d = RESET_PLL;
        FAIL:   state_d = FAIL;
        default: state_d = RESET_PLL;
      endcase
    end
    if (restart || (state_d != state_q)) cnt_d = '0;
  end

  // Outputs decode the next state so they change in the same cycle as seq_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RESET_PLL;
      cnt_q          <= '0;
      retry_q        <= '0;
      qpll0reset_q   <= MASK;
      qpll1reset_q   <= 2'b11;
      gt_reset_req_q <= 1'b1;
      qpll_locked_q  <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      qpll0reset_q   <= (state_d == RESET_PLL) ? MASK : 2'b00;
      qpll1reset_q   <= 2'b11;
      gt_reset_req_q <= (state_d != LOCKED);
      qpll_locked_q  <= (state_d == LOCKED);
      timeout_err_q  <= (state_d == FAIL);
    end
  end

  assign qpll0reset   = qpll0reset_q;
  assign qpll1reset   = qpll1reset_q;
  assign gt_reset_req = gt_reset_req_q;
  assign qpll_locked  = qpll_locked_q;
  assign timeout_err  = timeout_err_q;
  assign retry_cnt    = retry_q;
  assign seq_state    = state_q;

endmodule

// File: tb/tb_gt_usplus_qpll_reset_sequencer.sv
// Directed bench for the QPLL0 reset sequencer: dual-quad instance plus a single-quad instance.
module tb_gt_usplus_qpll_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, restart;
  logic [1:0] lock, q0r, q1r, retry;
  logic       gtr, lkd, terr;
  logic [2:0] seq;

  logic       rst_b_n, restart_b;
  logic [1:0] lock_b, q0r_b, q1r_b, retry_b;
  logic       gtr_b, lkd_b, terr_b;
  logic [2:0] seq_b;

  int checks = 0;
  int errors = 0;
  int n;
  int bit1_seen;

  gt_usplus_qpll_reset_sequencer #(
    .N_COMMON(2), .RESET_PULSE_CYCLES(4), .LOCK_TIMEOUT_CYCLES(50),
    .LOCK_STABLE_CYCLES(8), .MAX_RETRIES(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .qpll0lock(lock),
    .qpll0reset(q0r), .qpll1reset(q1r), .gt_reset_req(gtr), .qpll_locked(lkd),
    .timeout_err(terr), .retry_cnt(retry), .seq_state(seq)
  );

  gt_usplus_qpll_reset_sequencer #(
    .N_COMMON(1), .RESET_PULSE_CYCLES(4), .LOCK_TIMEOUT_CYCLES(50),
    .LOCK_STABLE_CYCLES(8), .MAX_RETRIES(2)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .restart(restart_b), .qpll0lock(lock_b),
    .qpll0reset(q0r_b), .qpll1reset(q1r_b), .gt_reset_req(gtr_b), .qpll_locked(lkd_b),
    .timeout_err(terr_b), .retry_cnt(retry_b), .seq_state(seq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  // Cycles qpll0reset stays asserted, starting from the current sample.
  task automatic pulse_len(output int len);
    len = 0;
    while (q0r !== 2'b00 && len < 100) begin
      len++;
      step(1);
    end
  endtask

  task automatic wait_len(input logic [2:0] code, output int len);
    len = 0;
    while (seq === code && len < 200) begin
      len++;
      step(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; restart = 1'b0; lock = 2'b00;
    rst_b_n = 1'b0; restart_b = 1'b0; lock_b = 2'b01;
    #23;
    chk("rst_q0r", 32'(q0r), 32'h3);
    chk("rst_q1r", 32'(q1r), 32'h3);
    chk("rst_gtr", 32'(gtr), 32'h1);
    chk("rst_lkd", 32'(lkd), 32'h0);
    chk("rst_terr", 32'(terr), 32'h0);
    chk("rst_retry", 32'(retry), 32'h0);
    chk("rst_seq", 32'(seq), 32'h0);
    chk("rst_b_q0r", 32'(q0r_b), 32'h1);

    // 1: first lock, 10-cycle total qualification latency
    step(1); rst_n = 1'b1;
    pulse_len(n);
    chk("t1_pulse", 32'(n), 32'd4);
    chk("t1_wait", 32'(seq), 32'd1);
    step(10); lock = 2'b11;
    step(9);
    chk("t1_stable", 32'(seq), 32'd2);
    chk("t1_lkd_early", 32'(lkd), 32'h0);
    chk("t1_gtr_early", 32'(gtr), 32'h1);
    step(1);
    chk("t1_locked", 32'(seq), 32'd3);
    chk("t1_lkd", 32'(lkd), 32'h1);
    chk("t1_gtr", 32'(gtr), 32'h0);
    chk("t1_q0r", 32'(q0r), 32'h0);

    // 4: lock[0] loss while LOCKED
    lock = 2'b10;
    step(2);
    chk("t4_still", 32'(lkd), 32'h1);
    step(1);
    chk("t4_seq", 32'(seq), 32'd0);
    chk("t4_gtr", 32'(gtr), 32'h1);
    chk("t4_lkd", 32'(lkd), 32'h0);
    chk("t4_q0r", 32'(q0r), 32'h3);
    lock = 2'b11;
    pulse_len(n);
    chk("t4_pulse", 32'(n), 32'd4);
    wait_len(3'd1, n);
    chk("t4_waitlen", 32'(n), 32'd1);
    wait_len(3'd2, n);
    chk("t4_stablen", 32'(n), 32'd7);
    chk("t4_relock", 32'(seq), 32'd3);
    chk("t4_retry", 32'(retry), 32'd0);

    // 2: lock never rises -> retries then FAIL
    restart = 1'b1; lock = 2'b00;
    step(1); restart = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pulse_len(n);
      chk("t2_pulse", 32'(n), 32'd4);
      chk("t2_retry", 32'(retry), 32'(p));
      wait_len(3'd1, n);
      chk("t2_timeout", 32'(n), 32'd50);
    end
    chk("t2_fail", 32'(seq), 32'd4);
    chk("t2_terr", 32'(terr), 32'h1);
    chk("t2_q0r", 32'(q0r), 32'h0);
    chk("t2_gtr", 32'(gtr), 32'h1);
    chk("t2_lkd", 32'(lkd), 32'h0);
    chk("t2_retry_sat", 32'(retry), 32'd2);
    step(5);
    chk("t2_fail_hold", 32'(seq), 32'd4);
    restart = 1'b1;
    step(1); restart = 1'b0;
    chk("t2_rs_seq", 32'(seq), 32'd0);
    chk("t2_rs_terr", 32'(terr), 32'h0);
    chk("t2_rs_retry", 32'(retry), 32'd0);
    pulse_len(n);
    chk("t2_rs_pulse", 32'(n), 32'd4);

    // 3: one-cycle lock[1] glitch inside the stable window (retry_cnt = 1)
    wait_len(3'd1, n);
    chk("t3_timeout", 32'(n), 32'd50);
    pulse_len(n);
    chk("t3_pulse", 32'(n), 32'd4);
    chk("t3_retry0", 32'(retry), 32'd1);
    lock = 2'b11;
    step(6); lock = 2'b01;
    step(1); lock = 2'b11;
    step(2);
    chk("t3_back", 32'(seq), 32'd1);
    chk("t3_retry1", 32'(retry), 32'd1);
    step(7);
    chk("t3_restable", 32'(seq), 32'd2);
    step(1);
    chk("t3_locked", 32'(seq), 32'd3);
    chk("t3_lkd", 32'(lkd), 32'h1);
    chk("t3_retry2", 32'(retry), 32'd1);

    // 6: restart coincident with timeout, then async reset mid-WAIT_LOCK
    restart = 1'b1; lock = 2'b00;
    step(1); restart = 1'b0;
    pulse_len(n);
    chk("t6_pulse", 32'(n), 32'd4);
    step(49);
    chk("t6_pre", 32'(seq), 32'd1);
    restart = 1'b1;
    step(1); restart = 1'b0;
    chk("t6_seq", 32'(seq), 32'd0);
    chk("t6_retry", 32'(retry), 32'd0);
    chk("t6_terr", 32'(terr), 32'h0);
    chk("t6_q0r", 32'(q0r), 32'h3);
    pulse_len(n);
    chk("t6_pulse2", 32'(n), 32'd4);
    wait_len(3'd1, n);
    chk("t6_timeout", 32'(n), 32'd50);
    pulse_len(n);
    step(10);
    chk("t6_mid", 32'(seq), 32'd1);
    chk("t6_mid_retry", 32'(retry), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("t6_arst_seq", 32'(seq), 32'd0);
    chk("t6_arst_retry", 32'(retry), 32'd0);
    chk("t6_arst_q0r", 32'(q0r), 32'h3);
    chk("t6_arst_gtr", 32'(gtr), 32'h1);
    step(2); rst_n = 1'b1;
    pulse_len(n);
    chk("t6_rel_pulse", 32'(n), 32'd4);
    chk("t6_rel_seq", 32'(seq), 32'd1);
    chk("t6_q1r", 32'(q1r), 32'h3);

    // 5: single-quad instance
    rst_b_n = 1'b1;
    n = 0; bit1_seen = 0;
    while (q0r_b !== 2'b00 && n < 100) begin
      if (q0r_b[1] !== 1'b0) bit1_seen = 1;
      if (q1r_b !== 2'b11) bit1_seen = 1;
      n++;
      step(1);
    end
    chk("t5_pulse", 32'(n), 32'd4);
    chk("t5_bit1", 32'(bit1_seen), 32'd0);
    chk("t5_wait", 32'(seq_b), 32'd1);
    step(7);
    chk("t5_stable", 32'(seq_b), 32'd2);
    step(1);
    chk("t5_locked", 32'(seq_b), 32'd3);
    chk("t5_lkd", 32'(lkd_b), 32'h1);
    chk("t5_gtr", 32'(gtr_b), 32'h0);
    chk("t5_q1r", 32'(q1r_b), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
